// File: rtl/sa_result_streamer.sv
// Result streamer: snapshots the systolic array result bus on load and
// drains it one element per valid/ready beat, row- or column-major.
module sa_result_streamer #(
  parameter int WIDTH      = 8,
  parameter int ARRAY_SIZE = 4,
  parameter int SUM_W      = 2*WIDTH+2,
  parameter int OUT_W      = 2*WIDTH+2,
  localparam int N  = ARRAY_SIZE,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SUM_W*N*N-1:0]    result_in,
  input  logic                    load,
  input  logic                    col_major,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic [RW-1:0]           m_row,
  output logic [RW-1:0]           m_col,
  output logic                    m_last,
  output logic                    m_sat,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int NN = N*N;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_e;

  state_e               st_q, st_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [SUM_W*NN-1:0]  snap_q, snap_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;

  logic                 xfer;
  logic                 last;

  assign xfer = (st_q == S_STREAM) && m_ready;
  assign last = (idx_q == IW'(NN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      idx_q  <= '0;
      snap_q <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      mode_q <= mode_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    mode_d = mode_q;
    done_d = 1'b0;
    ovr_d  = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (load) begin
          st_d   = S_STREAM;
          idx_d  = '0;
          snap_d = result_in;
          mode_d = col_major;
        end
      end
      S_STREAM: begin
        if (xfer && last) begin
          done_d = 1'b1;
          idx_d  = '0;
          // a load landing on the final beat chains straight into a new stream
          if (load) begin
            snap_d = result_in;
            mode_d = col_major;
          end else begin
            st_d = S_IDLE;
          end
        end else begin
          if (xfer) idx_d = idx_q + 1'b1;
          if (load) ovr_d = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  logic [IW-1:0]           q_w, r_w, sel;
  logic [IW-1:0]           row_w, col_w;
  logic signed [SUM_W-1:0] elem;
  logic signed [OUT_W-1:0] nar;
  logic                    nar_sat;

  always_comb begin
    q_w   = idx_q / IW'(N);
    r_w   = idx_q % IW'(N);
    row_w = mode_q ? r_w : q_w;
    col_w = mode_q ? q_w : r_w;
    sel   = mode_q ? IW'(r_w * IW'(N) + q_w) : idx_q;
    elem  = '0;
    for (int k = 0; k < NN; k++) begin
      if (sel == k[IW-1:0]) elem = snap_q[k*SUM_W +: SUM_W];
    end
  end

  if (OUT_W >= SUM_W) begin : g_ext
    assign nar     = OUT_W'(elem);
    assign nar_sat = 1'b0;
  end else begin : g_sat
    localparam logic signed [SUM_W-1:0] MAXV =
      {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MINV =
      {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    always_comb begin
      nar     = elem[OUT_W-1:0];
      nar_sat = 1'b0;
      if (elem > MAXV) begin
        nar     = {1'b0, {(OUT_W-1){1'b1}}};
        nar_sat = 1'b1;
      end else if (elem < MINV) begin
        nar     = {1'b1, {(OUT_W-1){1'b0}}};
        nar_sat = 1'b1;
      end
    end
  end

  always_comb begin
    busy    = (st_q == S_STREAM);
    m_valid = busy;
    m_data  = busy ? nar : '0;
    m_row   = busy ? RW'(row_w) : '0;
    m_col   = busy ? RW'(col_w) : '0;
    m_last  = busy && last;
    m_sat   = busy && nar_sat;
    done    = done_q;
    overrun = ovr_q;
  end

endmodule

// File: tb/tb_sa_result_streamer.sv
// Directed bench: default, 8-bit saturating and 32-bit sign-extending
// streamers driven in lockstep from shared control.
module tb_sa_result_streamer;

  logic clk = 1'b0;
  logic rst_n;
  logic load, col_major, m_ready;
  logic [18*16-1:0] res0, res8, res32;

  logic v0, l0, s0, b0, dn0, ov0;
  logic [17:0] d0;
  logic [1:0] r0, c0;
  logic v8, l8, s8, b8, dn8, ov8;
  logic [7:0] d8;
  logic [1:0] r8, c8;
  logic v32, l32, s32, b32, dn32, ov32;
  logic [31:0] d32;
  logic [1:0] r32, c32;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] e8 [5] = '{8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80};
  logic       es8 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  sa_result_streamer u0 (
    .clk(clk), .rst_n(rst_n), .result_in(res0),
    .load(load), .col_major(col_major),
    .m_valid(v0), .m_ready(m_ready), .m_data(d0),
    .m_row(r0), .m_col(c0), .m_last(l0), .m_sat(s0),
    .busy(b0), .done(dn0), .overrun(ov0)
  );

  sa_result_streamer #(.OUT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .result_in(res8),
    .load(load), .col_major(col_major),
    .m_valid(v8), .m_ready(m_ready), .m_data(d8),
    .m_row(r8), .m_col(c8), .m_last(l8), .m_sat(s8),
    .busy(b8), .done(dn8), .overrun(ov8)
  );

  sa_result_streamer #(.OUT_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .result_in(res32),
    .load(load), .col_major(col_major),
    .m_valid(v32), .m_ready(m_ready), .m_data(d32),
    .m_row(r32), .m_col(c32), .m_last(l32), .m_sat(s32),
    .busy(b32), .done(dn32), .overrun(ov32)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill0(input int base);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res0[(r*4+c)*18 +: 18] = 18'(base + 10*r + c);
  endtask

  task automatic do_load(input logic cm);
    load = 1'b1;
    col_major = cm;
    tick();
    load = 1'b0;
  endtask

  task automatic run_stream(input logic cm, input logic bp);
    int beat = 0;
    int cyc = 0;
    int er, ec;
    do_load(cm);
    while (beat < 16 && cyc < 100) begin
      m_ready = bp ? (cyc % 3 == 0) : 1'b1;
      er = cm ? beat % 4 : beat / 4;
      ec = cm ? beat / 4 : beat % 4;
      chk("valid", 64'(v0), 64'(1));
      chk("busy", 64'(b0), 64'(1));
      chk("done_mid", 64'(dn0), 64'(0));
      chk("data", 64'(d0), 64'(10*er + ec));
      chk("row", 64'(r0), 64'(er));
      chk("col", 64'(c0), 64'(ec));
      chk("last", 64'(l0), 64'(beat == 15));
      if (!cm && beat < 5) begin
        chk("sat_data", 64'(d8), 64'(e8[beat]));
        chk("sat_flag", 64'(s8), 64'(es8[beat]));
      end
      if (!cm && beat == 0) begin
        chk("sext_data", 64'(d32), 64'h0000_0000_FFFF_FFFF);
        chk("sext_flag", 64'(s32), 64'(0));
      end
      tick();
      if (m_ready) beat++;
      cyc++;
    end
    chk("beats", 64'(beat), 64'(16));
    m_ready = 1'b1;
    chk("done", 64'(dn0), 64'(1));
    chk("busy_end", 64'(b0), 64'(0));
    chk("valid_end", 64'(v0), 64'(0));
    tick();
    chk("done_1cyc", 64'(dn0), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    col_major = 1'b0;
    m_ready = 1'b0;
    fill0(0);
    res8 = '0;
    res8[0*18 +: 18] = 18'd127;
    res8[1*18 +: 18] = 18'd128;
    res8[2*18 +: 18] = 18'h3FF80;
    res8[3*18 +: 18] = 18'h3FF7F;
    res8[4*18 +: 18] = 18'h3FED4;
    res32 = '0;
    res32[0 +: 18] = 18'h3FFFF;
    #1;
    chk("rst_valid", 64'(v0), 64'(0));
    chk("rst_busy", 64'(b0), 64'(0));
    chk("rst_done", 64'(dn0), 64'(0));
    chk("rst_ovr", 64'(ov0), 64'(0));
    chk("rst_data", 64'(d0), 64'(0));
    chk("rst_last", 64'(l0), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    run_stream(1'b0, 1'b0);
    run_stream(1'b1, 1'b0);
    run_stream(1'b0, 1'b1);

    m_ready = 1'b1;
    do_load(1'b0);
    repeat (5) tick();
    chk("b5_data", 64'(d0), 64'(11));
    fill0(100);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("ovr_pulse", 64'(ov0), 64'(1));
    chk("ovr_data", 64'(d0), 64'(12));
    chk("ovr_col", 64'(c0), 64'(2));
    tick();
    chk("ovr_clr", 64'(ov0), 64'(0));
    chk("b7_data", 64'(d0), 64'(13));
    repeat (8) tick();
    chk("b15_last", 64'(l0), 64'(1));
    chk("b15_data", 64'(d0), 64'(33));
    col_major = 1'b1;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("b2b_done", 64'(dn0), 64'(1));
    chk("b2b_valid", 64'(v0), 64'(1));
    chk("b2b_ovr", 64'(ov0), 64'(0));
    chk("b2b_data", 64'(d0), 64'(100));
    chk("b2b_row", 64'(r0), 64'(0));
    chk("b2b_col", 64'(c0), 64'(0));
    tick();
    chk("b2b_data1", 64'(d0), 64'(110));
    chk("b2b_row1", 64'(r0), 64'(1));
    repeat (6) tick();
    chk("b2b_data7", 64'(d0), 64'(131));

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(v0), 64'(0));
    chk("arst_busy", 64'(b0), 64'(0));
    chk("arst_data", 64'(d0), 64'(0));
    chk("arst_row", 64'(r0), 64'(0));
    chk("arst_col", 64'(c0), 64'(0));
    tick();
    chk("arst_done", 64'(dn0), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("post_done", 64'(dn0), 64'(0));
    fill0(0);
    run_stream(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
